// File: rtl/uart_pkg.sv
// uart_pkg: state encoding, legal prescale values and default word width
// shared by the UART receiver files.
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;
    localparam int PS_8 = 8;
    localparam int PS_16 = 16;
    localparam int PS_32 = 32;
    localparam int DEF_DATA_WIDTH = 8;
endpackage

// File: rtl/uart_rx_edge_cnt.sv
// uart_rx_edge_cnt: per-bit edge counter (0..pre-1) and data bit counter.
module uart_rx_edge_cnt (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       edge_clr_i,
    input  logic       bit_clr_i,
    input  logic       bit_inc_i,
    input  logic [5:0] pre_i,
    output logic [5:0] ecnt_o,
    output logic [3:0] bcnt_o
);
    logic [5:0] ecnt_q, ecnt_d;
    logic [3:0] bcnt_q, bcnt_d;

    always_comb begin
        ecnt_d = (edge_clr_i || ecnt_q == pre_i - 6'd1) ? '0 : ecnt_q + 6'd1;
        bcnt_d = bit_clr_i ? '0 : bit_inc_i ? bcnt_q + 4'd1 : bcnt_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ecnt_q <= '0;
            bcnt_q <= '0;
        end else begin
            ecnt_q <= ecnt_d;
            bcnt_q <= bcnt_d;
        end
    end

    assign ecnt_o = ecnt_q;
    assign bcnt_o = bcnt_q;
endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parameterised UART receiver with optional parity and bit order.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority bit sampling.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] PRESCALE,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  MSB_FIRST,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR,
    output logic                  BUSY
);
    rx_state_e state_q, state_d;
    logic [5:0] pre_q, pre_d, ecnt, half;
    logic [3:0] bcnt;
    logic par_en_q, par_en_d, typ_q, typ_d, msb_q, msb_d;
    logic [DATA_WIDTH-1:0] sh_q, sh_d, data_q, data_d;
    logic par_q, par_d, perr_q, perr_d, dv_q, dv_d, pe_q, pe_d, se_q, se_d;
    logic s_mid_q, s_mid_d, bit_v, dec, wrap;

    assign half = {1'b0, pre_q[5:1]};
    assign dec = ecnt == half + 6'd1;
    assign wrap = ecnt == pre_q - 6'd1;
    assign s_mid_d = (ecnt == half) ? RX_IN : s_mid_q;

`ifdef UART_RX_MAJORITY_EN
    logic s_lo_q;
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) s_lo_q <= 1'b0;
        else if (ecnt == half - 6'd1) s_lo_q <= RX_IN;
    end
    // third vote is the live line value at the decision edge
    assign bit_v = (s_lo_q & s_mid_q) | (s_lo_q & RX_IN) | (s_mid_q & RX_IN);
`else
    assign bit_v = s_mid_q;
`endif

    uart_rx_edge_cnt u_cnt (
        .clk_i      (CLK),
        .rst_i      (RST),
        .edge_clr_i (state_q == IDLE),
        .bit_clr_i  (state_q != DATA),
        .bit_inc_i  (state_q == DATA && wrap),
        .pre_i      (pre_q),
        .ecnt_o     (ecnt),
        .bcnt_o     (bcnt)
    );

    always_comb begin
        state_d = state_q;
        pre_d = pre_q;
        par_en_d = par_en_q;
        typ_d = typ_q;
        msb_d = msb_q;
        sh_d = sh_q;
        data_d = data_q;
        par_d = par_q;
        perr_d = perr_q;
        dv_d = 1'b0;
        pe_d = 1'b0;
        se_d = 1'b0;
        case (state_q)
            IDLE: begin
                par_d = 1'b0;
                perr_d = 1'b0;
                if (!RX_IN) begin
                    state_d = START;
                    pre_d = (PRESCALE == PRESCALE_W'(PS_16) || PRESCALE == PRESCALE_W'(PS_32))
                            ? 6'(PRESCALE) : 6'(PS_8);
                    par_en_d = PAR_EN;
                    typ_d = PAR_TYP;
                    msb_d = MSB_FIRST;
                end
            end
            START: state_d = (dec && bit_v) ? IDLE : wrap ? DATA : START;
            DATA: begin
                if (dec) begin
                    sh_d = msb_q ? {sh_q[DATA_WIDTH-2:0], bit_v} : {bit_v, sh_q[DATA_WIDTH-1:1]};
                    par_d = par_q ^ bit_v;
                end
                if (wrap && bcnt == 4'(DATA_WIDTH - 1)) state_d = par_en_q ? PARITY : STOP;
            end
            PARITY: begin
                if (dec) perr_d = bit_v != (par_q ^ typ_q);
                if (wrap) state_d = STOP;
            end
            STOP: if (dec) begin
                state_d = IDLE;
                pe_d = perr_q;
                se_d = !bit_v;
                dv_d = !perr_q && bit_v;
                data_d = (!perr_q && bit_v) ? sh_q : data_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            pre_q <= 6'(PS_8);
            par_en_q <= 1'b0;
            typ_q <= 1'b0;
            msb_q <= 1'b0;
            sh_q <= '0;
            data_q <= '0;
            par_q <= 1'b0;
            perr_q <= 1'b0;
            dv_q <= 1'b0;
            pe_q <= 1'b0;
            se_q <= 1'b0;
            s_mid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q <= pre_d;
            par_en_q <= par_en_d;
            typ_q <= typ_d;
            msb_q <= msb_d;
            sh_q <= sh_d;
            data_q <= data_d;
            par_q <= par_d;
            perr_q <= perr_d;
            dv_q <= dv_d;
            pe_q <= pe_d;
            se_q <= se_d;
            s_mid_q <= s_mid_d;
        end
    end

    assign P_DATA = data_q;
    assign DATA_VALID = dv_q;
    assign PAR_ERR = pe_q;
    assign STP_ERR = se_q;
    assign BUSY = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: randomized frames checked against a frame-level model
// of the receiver (expected word, pulse counts, held data).
module tb_uart_rx_param;
    logic CLK = 1'b0, RST = 1'b1, RX_IN = 1'b1;
    logic PAR_EN = 1'b0, PAR_TYP = 1'b0, MSB_FIRST = 1'b0;
    logic [5:0] PRESCALE = 6'd8;
    logic [7:0] P_DATA;
    logic DATA_VALID, PAR_ERR, STP_ERR, BUSY;

    int n_chk = 0, n_fail = 0;
    int dv_n = 0, pe_n = 0, se_n = 0;
    logic [7:0] dv_hist[$];
    logic [7:0] exp_data = 8'h00;

    always #5 CLK = ~CLK;

    uart_rx_param dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PRESCALE   (PRESCALE),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .MSB_FIRST  (MSB_FIRST),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_ERR    (PAR_ERR),
        .STP_ERR    (STP_ERR),
        .BUSY       (BUSY)
    );

    always @(negedge CLK) begin
        if (DATA_VALID) begin
            dv_n++;
            dv_hist.push_back(P_DATA);
        end
        if (PAR_ERR) pe_n++;
        if (STP_ERR) se_n++;
    end

    task automatic send_frame(input logic [7:0] d, input int pre, input logic [5:0] pre_port,
                              input logic pe, input logic typ, input logic msb,
                              input logic bad_par, input logic stop, input logic scramble, input int idle);
        logic b[$];
        @(negedge CLK);
        PRESCALE = pre_port;
        PAR_EN = pe;
        PAR_TYP = typ;
        MSB_FIRST = msb;
        b.push_back(1'b0);
        for (int i = 0; i < 8; i++) b.push_back(msb ? d[7-i] : d[i]);
        if (pe) b.push_back((^d) ^ typ ^ bad_par);
        b.push_back(stop);
        for (int k = 0; k < b.size(); k++) begin
            RX_IN = b[k];
            for (int j = 0; j < pre; j++) begin
                @(negedge CLK);
                if (scramble && k == 0 && j == 0) begin
                    PRESCALE = 6'($urandom);
                    PAR_EN = 1'($urandom);
                    PAR_TYP = 1'($urandom);
                    MSB_FIRST = 1'($urandom);
                end
            end
        end
        RX_IN = 1'b1;
        repeat (idle) @(negedge CLK);
    endtask

    task automatic test_frame(input string name, input logic [7:0] d, input int pre, input logic [5:0] pre_port,
                              input logic pe, input logic typ, input logic msb,
                              input logic bad_par, input logic stop, input logic scramble);
        int dv0, pe0, se0, want_dv, want_pe, want_se;
        dv0 = dv_n;
        pe0 = pe_n;
        se0 = se_n;
        send_frame(d, pre, pre_port, pe, typ, msb, bad_par, stop, scramble, 2 * pre + 4);
        want_pe = (pe && bad_par) ? 1 : 0;
        want_se = stop ? 0 : 1;
        want_dv = (want_pe == 0 && want_se == 0) ? 1 : 0;
        if (want_dv == 1) exp_data = d;
        n_chk++;
        if (dv_n - dv0 != want_dv) begin
            n_fail++;
            $display("FAIL %s dv_pulses got %0d want %0d", name, dv_n - dv0, want_dv);
        end
        n_chk++;
        if (pe_n - pe0 != want_pe) begin
            n_fail++;
            $display("FAIL %s par_err_pulses got %0d want %0d", name, pe_n - pe0, want_pe);
        end
        n_chk++;
        if (se_n - se0 != want_se) begin
            n_fail++;
            $display("FAIL %s stp_err_pulses got %0d want %0d", name, se_n - se0, want_se);
        end
        n_chk++;
        if (P_DATA !== exp_data) begin
            n_fail++;
            $display("FAIL %s p_data got %h want %h", name, P_DATA, exp_data);
        end
        n_chk++;
        if (BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy_after got %b want 0", name, BUSY);
        end
    endtask

    task automatic test_reset();
        n_chk++;
        if ({P_DATA, DATA_VALID, PAR_ERR, STP_ERR, BUSY} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_outputs got %h want 000", {P_DATA, DATA_VALID, PAR_ERR, STP_ERR, BUSY});
        end
        RST = 1'b0;
        repeat (4) @(negedge CLK);
        n_chk++;
        if (BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_busy got %b want 0", BUSY);
        end
    endtask

    task automatic test_glitch();
        int dv0, pe0, se0;
        dv0 = dv_n;
        pe0 = pe_n;
        se0 = se_n;
        @(negedge CLK);
        PRESCALE = 6'd8;
        RX_IN = 1'b0;
        repeat (2) @(negedge CLK);
        RX_IN = 1'b1;
        n_chk++;
        if (BUSY !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_busy_during got %b want 1", BUSY);
        end
        repeat (20) @(negedge CLK);
        n_chk++;
        if (BUSY !== 1'b0 || dv_n != dv0 || pe_n != pe0 || se_n != se0) begin
            n_fail++;
            $display("FAIL glitch_reject busy %b pulses %0d want busy 0 pulses 0", BUSY,
                     (dv_n - dv0) + (pe_n - pe0) + (se_n - se0));
        end
    endtask

    task automatic test_reset_mid();
        int tot0;
        @(negedge CLK);
        PRESCALE = 6'd8;
        PAR_EN = 1'b0;
        MSB_FIRST = 1'b0;
        RX_IN = 1'b0;
        repeat (8) @(negedge CLK);
        RX_IN = 1'b1;
        repeat (8) @(negedge CLK);
        RX_IN = 1'b0;
        repeat (4) @(negedge CLK);
        n_chk++;
        if (BUSY !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_busy_before got %b want 1", BUSY);
        end
        tot0 = dv_n + pe_n + se_n;
        RST = 1'b1;
        #1;
        n_chk++;
        if ({P_DATA, DATA_VALID, PAR_ERR, STP_ERR, BUSY} !== 12'h000) begin
            n_fail++;
            $display("FAIL rst_mid_outputs got %h want 000", {P_DATA, DATA_VALID, PAR_ERR, STP_ERR, BUSY});
        end
        RX_IN = 1'b1;
        exp_data = 8'h00;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        repeat (40) @(negedge CLK);
        n_chk++;
        if (dv_n + pe_n + se_n != tot0 || BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_abandon pulses %0d busy %b want 0 0", dv_n + pe_n + se_n - tot0, BUSY);
        end
        test_frame("rst_mid_next", 8'hF0, 8, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        int dv0, pe0, se0;
        logic [7:0] w[3];
        w[0] = 8'h01;
        w[1] = 8'h80;
        w[2] = 8'hFF;
        dv0 = dv_n;
        pe0 = pe_n;
        se0 = se_n;
        for (int i = 0; i < 3; i++) send_frame(w[i], 32, 6'd32, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0);
        repeat (10) @(negedge CLK);
        n_chk++;
        if (dv_n - dv0 != 3 || pe_n != pe0 || se_n != se0) begin
            n_fail++;
            $display("FAIL b2b_pulses dv %0d pe %0d se %0d want 3 0 0", dv_n - dv0, pe_n - pe0, se_n - se0);
        end
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (dv_hist.size() < 3 || dv_hist[dv_hist.size() - 3 + i] !== w[i]) begin
                n_fail++;
                $display("FAIL b2b_word%0d got %h want %h", i,
                         (dv_hist.size() < 3) ? 8'hxx : dv_hist[dv_hist.size() - 3 + i], w[i]);
            end
        end
        exp_data = 8'hFF;
    endtask

    task automatic test_random();
        int pre;
        logic pe, bad;
        for (int i = 0; i < 12; i++) begin
            pre = 8 << $urandom_range(0, 2);
            pe = 1'($urandom);
            bad = pe && ($urandom_range(0, 5) == 0);
            test_frame("random", 8'($urandom), pre, 6'(pre), pe, 1'($urandom), 1'($urandom),
                       bad, $urandom_range(0, 5) != 0, 1'($urandom));
        end
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        test_reset();
        test_frame("par_ok_55", 8'h55, 8, 6'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        test_frame("par_err_55", 8'h55, 8, 6'd8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        test_frame("stp_err_a3", 8'hA3, 16, 6'd16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        test_frame("good_3c", 8'h3C, 16, 6'd16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        test_glitch();
        test_reset_mid();
        test_back_to_back();
        test_frame("illegal_pre", 8'h96, 8, 6'd12, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
